// File: rtl/input_debouncer_pkg.sv
// Shared types and helpers for the input debouncer.
package input_debouncer_pkg;

    typedef enum logic [0:0] {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } deb_state_t;

    // Width of the per-channel mismatch counter: enough to hold 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/input_debouncer_if.sv
// Debouncer signal bundle: sampling enable and raw pads in, clean levels and pulses out.
interface input_debouncer_if #(
    parameter int CHANNELS = 2
);
    logic                sample_tick;
    logic [CHANNELS-1:0] raw_in;
    logic [CHANNELS-1:0] level_out;
    logic [CHANNELS-1:0] rise_out;
    logic [CHANNELS-1:0] fall_out;
    logic                changed;

    modport master (
        output sample_tick, raw_in,
        input  level_out, rise_out, fall_out, changed
    );

    modport slave (
        input  sample_tick, raw_in,
        output level_out, rise_out, fall_out, changed
    );
endinterface

// File: rtl/input_debouncer_channel.sv
// Single-bit synchroniser, debounce FSM, counter and edge pulse registers.
module debounce_channel
    import input_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rise_nxt,
    output logic fall_nxt
);
    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    deb_state_t             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, fall_q;
    logic                   mismatch;
    logic                   commit;

    // Synchroniser chain shifts every clock, independent of sample_tick.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end

    assign sync     = sync_q[SYNC_STAGES-1];
    assign mismatch = (sync != level_q);

    // Next-state logic: count ticked mismatches, drop back on a bounce, toggle on the last one.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        commit   = 1'b0;
        rise_nxt = 1'b0;
        fall_nxt = 1'b0;
        case (state_q)
            STABLE: begin
                if (mismatch) begin
                    if (sample_tick) begin
                        // Entry cycle counts as the first mismatch when ticked.
                        if (DEBOUNCE_CYCLES == 1) begin
                            commit = 1'b1;
                        end else begin
                            state_d = PENDING;
                            cnt_d   = CW'(1);
                        end
                    end else begin
                        state_d = PENDING;
                        cnt_d   = '0;
                    end
                end
            end
            PENDING: begin
                if (!mismatch) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (sample_tick) begin
                    if (cnt_q == CNT_LAST) commit = 1'b1;
                    else                   cnt_d  = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
        if (commit) begin
            level_d  = ~level_q;
            state_d  = STABLE;
            cnt_d    = '0;
            rise_nxt = ~level_q;
            fall_nxt = level_q;
        end
    end

    // FSM, counter, level and pulse registers; reset never produces a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_nxt;
            fall_q  <= fall_nxt;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
endmodule

// File: rtl/input_debouncer.sv
// Multi-channel input debouncer: independent channels plus a combined change strobe.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int CHANNELS        = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input logic               clk,
    input logic               rst,
    input_debouncer_if.slave  bus
);
    logic [CHANNELS-1:0] level_w;
    logic [CHANNELS-1:0] rise_w;
    logic [CHANNELS-1:0] fall_w;
    logic [CHANNELS-1:0] rise_nxt_w;
    logic [CHANNELS-1:0] fall_nxt_w;
    logic                changed_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .sample_tick (bus.sample_tick),
            .raw         (bus.raw_in[i]),
            .level       (level_w[i]),
            .rise        (rise_w[i]),
            .fall        (fall_w[i]),
            .rise_nxt    (rise_nxt_w[i]),
            .fall_nxt    (fall_nxt_w[i])
        );
    end

    // Change strobe registered from the pulse next-values so it lines up with the pulses.
    always_ff @(posedge clk) begin
        if (rst) changed_q <= 1'b0;
        else     changed_q <= |(rise_nxt_w | fall_nxt_w);
    end

    assign bus.level_out = level_w;
    assign bus.rise_out  = rise_w;
    assign bus.fall_out  = fall_w;
    assign bus.changed   = changed_q;
endmodule

// File: tb/tb_input_debouncer.sv
// Directed testbench for input_debouncer (2 channels, 2 sync stages, 4 debounce cycles).
module tb_input_debouncer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    input_debouncer_if #(.CHANNELS(2)) bus ();

    input_debouncer #(
        .CHANNELS        (2),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .RESET_LEVEL     (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] lvl, input logic [1:0] ris,
                              input logic [1:0] fal, input logic chg);
        check({tag, ".level"},   {6'd0, bus.level_out}, {6'd0, lvl});
        check({tag, ".rise"},    {6'd0, bus.rise_out},  {6'd0, ris});
        check({tag, ".fall"},    {6'd0, bus.fall_out},  {6'd0, fal});
        check({tag, ".changed"}, {7'd0, bus.changed},   {7'd0, chg});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.sample_tick = 1'b1;
        bus.raw_in = 2'b11;

        // 1: reset with inputs high, then 6-edge latency to a dual rise.
        for (int k = 0; k < 3; k++) step();
        check_outs("rst_hold", 2'b00, 2'b00, 2'b00, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check_outs("pwr_wait", 2'b00, 2'b00, 2'b00, 1'b0);
        end
        step();
        check_outs("pwr_rise", 2'b11, 2'b11, 2'b00, 1'b1);
        step();
        check_outs("pwr_after", 2'b11, 2'b00, 2'b00, 1'b0);

        // Return both channels low.
        bus.raw_in = 2'b00;
        for (int k = 1; k <= 5; k++) step();
        step();
        check_outs("both_fall", 2'b00, 2'b00, 2'b11, 1'b1);
        for (int k = 0; k < 6; k++) step();

        // 2: bounce on ch0, three cycles high then three low, five times.
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 6; k++) begin
                bus.raw_in = (k < 3) ? 2'b01 : 2'b00;
                step();
                check("bounce.level0", {7'd0, bus.level_out[0]}, 8'd0);
                check("bounce.rise0",  {7'd0, bus.rise_out[0]},  8'd0);
            end
        end
        for (int k = 0; k < 8; k++) step();
        check_outs("bounce_end", 2'b00, 2'b00, 2'b00, 1'b0);

        // 3: clean press then release on ch1 with 20-cycle gaps.
        bus.raw_in = 2'b10;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("press_wait.rise1", {7'd0, bus.rise_out[1]}, 8'd0);
        end
        step();
        check_outs("press", 2'b10, 2'b10, 2'b00, 1'b1);
        for (int k = 0; k < 14; k++) begin
            step();
            check_outs("press_hold", 2'b10, 2'b00, 2'b00, 1'b0);
        end
        bus.raw_in = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("rel_wait.fall1", {7'd0, bus.fall_out[1]}, 8'd0);
        end
        step();
        check_outs("release", 2'b00, 2'b00, 2'b10, 1'b1);
        for (int k = 0; k < 14; k++) step();
        check_outs("release_hold", 2'b00, 2'b00, 2'b00, 1'b0);

        // 4: sample_tick one cycle in four, ch0 held high; commit on edge 16.
        for (int c = 0; c < 16; c++) begin
            bus.sample_tick = ((c % 4) == 3);
            if (c == 0) bus.raw_in = 2'b01;
            step();
            if (c < 15) check("slow_wait.level0", {7'd0, bus.level_out[0]}, 8'd0);
        end
        check_outs("slow_rise", 2'b01, 2'b01, 2'b00, 1'b1);
        bus.sample_tick = 1'b0;
        step();
        check_outs("slow_after", 2'b01, 2'b00, 2'b00, 1'b0);
        bus.sample_tick = 1'b1;

        // 5: reset while ch0 is pending with three mismatches counted.
        bus.raw_in = 2'b00;
        for (int k = 0; k < 8; k++) step();
        check_outs("pre_rst_low", 2'b00, 2'b00, 2'b00, 1'b0);
        bus.raw_in = 2'b01;
        for (int k = 1; k <= 5; k++) step();
        rst = 1'b1;
        step();
        check_outs("mid_rst", 2'b00, 2'b00, 2'b00, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check_outs("post_rst_wait", 2'b00, 2'b00, 2'b00, 1'b0);
        end
        step();
        check_outs("post_rst_rise", 2'b01, 2'b01, 2'b00, 1'b1);

        // 6: simultaneous opposite transitions 01 -> 10.
        for (int k = 0; k < 4; k++) step();
        bus.raw_in = 2'b10;
        for (int k = 1; k <= 5; k++) begin
            step();
            check_outs("swap_wait", 2'b01, 2'b00, 2'b00, 1'b0);
        end
        step();
        check_outs("swap", 2'b10, 2'b10, 2'b01, 1'b1);
        step();
        check_outs("swap_after", 2'b10, 2'b00, 2'b00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
